// File: rtl/regfile_port_arbiter.sv
// Register-file port arbiter: clears the file after reset, then arbitrates two
// write requesters round-robin and serves dual reads with write-through bypass.
module regfile_port_arbiter #(
    parameter int BUS_WIDTH  = 8,
    parameter int ADDR_WIDTH = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wa_valid,
    output logic                  wa_ready,
    input  logic [ADDR_WIDTH-1:0] wa_addr,
    input  logic [BUS_WIDTH-1:0]  wa_data,
    input  logic                  wb_valid,
    output logic                  wb_ready,
    input  logic [ADDR_WIDTH-1:0] wb_addr,
    input  logic [BUS_WIDTH-1:0]  wb_data,
    input  logic                  rd_req,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [ADDR_WIDTH-1:0] rd_addr_b,
    output logic                  rd_valid,
    output logic [BUS_WIDTH-1:0]  rd_data_a,
    output logic [BUS_WIDTH-1:0]  rd_data_b,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_wr_addr,
    output logic [BUS_WIDTH-1:0]  ram_wr_data,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_a,
    output logic [ADDR_WIDTH-1:0] ram_rd_addr_b,
    input  logic [BUS_WIDTH-1:0]  ram_rd_data_a,
    input  logic [BUS_WIDTH-1:0]  ram_rd_data_b,
    output logic                  init_done
);

    typedef enum logic {
        ST_INIT,
        ST_RUN
    } state_t;

    typedef enum logic {
        GRANT_A,
        GRANT_B
    } grant_t;

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_init_cnt;
    logic [ADDR_WIDTH-1:0] w_init_cnt_nxt;
    grant_t                r_last_grant;
    logic                  r_rd_valid;
    logic                  r_hit_a;
    logic                  r_hit_b;
    logic [BUS_WIDTH-1:0]  r_byp_data;

    logic                  w_in_init;
    logic                  w_in_run;
    logic                  w_open;
    logic                  w_a_sel;
    logic                  w_b_sel;
    logic                  w_a_fire;
    logic                  w_b_fire;
    logic                  w_wr_fire;
    logic                  w_rd_fire;
    logic [ADDR_WIDTH-1:0] w_wr_addr;
    logic [BUS_WIDTH-1:0]  w_wr_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_init_cnt <= w_init_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_init_cnt_nxt = r_init_cnt;
        w_in_init      = 1'b0;
        w_in_run       = 1'b0;
        unique case (r_state)
            ST_INIT: begin
                w_in_init      = 1'b1;
                w_init_cnt_nxt = r_init_cnt + 1'b1;
                if (r_init_cnt == LAST_ADDR) begin
                    w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                w_in_run = 1'b1;
            end
            default: begin
                w_state_nxt = ST_INIT;
            end
        endcase
    end

    // Handshakes are closed while reset is held so nothing commits mid-reset.
    assign w_open = w_in_run && !rst;

    assign w_a_sel = wa_valid &&
                     (!wb_valid || (r_last_grant == GRANT_B));
    assign w_b_sel = wb_valid &&
                     (!wa_valid || (r_last_grant == GRANT_A));

    assign wa_ready = w_open && w_a_sel;
    assign wb_ready = w_open && w_b_sel;
    assign rd_ready = w_open;

    assign w_a_fire  = wa_valid && wa_ready;
    assign w_b_fire  = wb_valid && wb_ready;
    assign w_wr_fire = w_a_fire || w_b_fire;
    assign w_rd_fire = rd_req && rd_ready;

    always_comb begin
        w_wr_addr = wa_addr;
        w_wr_data = wa_data;
        if (w_in_init) begin
            w_wr_addr = r_init_cnt;
            w_wr_data = '0;
        end else if (w_b_fire) begin
            w_wr_addr = wb_addr;
            w_wr_data = wb_data;
        end
    end

    assign ram_we        = !rst && (w_in_init || w_wr_fire);
    assign ram_wr_addr   = w_wr_addr;
    assign ram_wr_data   = w_wr_data;
    assign ram_rd_addr_a = rd_addr_a;
    assign ram_rd_addr_b = rd_addr_b;
    assign init_done     = w_in_run;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_grant <= GRANT_A;
        end else if (w_wr_fire) begin
            r_last_grant <= w_b_fire ? GRANT_B : GRANT_A;
        end
    end

    // The file returns the pre-write value, so a same-cycle write is forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_valid <= 1'b0;
            r_hit_a    <= 1'b0;
            r_hit_b    <= 1'b0;
            r_byp_data <= '0;
        end else begin
            r_rd_valid <= w_rd_fire;
            r_hit_a    <= w_rd_fire && w_wr_fire &&
                          (w_wr_addr == rd_addr_a);
            r_hit_b    <= w_rd_fire && w_wr_fire &&
                          (w_wr_addr == rd_addr_b);
            if (w_wr_fire) begin
                r_byp_data <= w_wr_data;
            end
        end
    end

    assign rd_valid  = r_rd_valid;
    assign rd_data_a = r_hit_a ? r_byp_data : ram_rd_data_a;
    assign rd_data_b = r_hit_b ? r_byp_data : ram_rd_data_b;

endmodule
